// File: rtl/latent_sampler.sv
// rtl/latent_sampler.sv - VAE reparameterisation sampler, z = mu + sigma*eps in Q8.8
// Buffers one pass of mu, pairs each sigma of the next pass with it, emits z through a 2-stage pipe.
module latent_sampler #(
  parameter int          N_LATENT  = 16,
  parameter int          IDX_W     = 4,
  parameter int          DATA_W    = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  input  logic              det_en,
  input  logic [DATA_W-1:0] det_eps,
  output logic              z_valid,
  input  logic              z_ready,
  output logic [DATA_W-1:0] z_data,
  output logic [IDX_W-1:0]  z_index,
  output logic              frame_done,
  output logic              mode_err
);

  typedef enum logic [1:0] {COLLECT_MU, COLLECT_SIG, DRAIN} state_t;

  localparam logic [IDX_W-1:0]  LAST = IDX_W'(N_LATENT - 1);
  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           cnt_q, cnt_d;
  logic [15:0]                lfsr_q, lfsr_d;
  logic [DATA_W-1:0]          mu_buf_q [N_LATENT];
  logic                       mu_we;
  logic                       s1_valid_q, s1_valid_d;
  logic signed [2*DATA_W-1:0] s1_prod_q, s1_prod_d;
  logic [DATA_W-1:0]          s1_mu_q, s1_mu_d;
  logic [IDX_W-1:0]           s1_idx_q, s1_idx_d;
  logic                       z_valid_q, z_valid_d;
  logic [DATA_W-1:0]          z_data_q, z_data_d;
  logic [IDX_W-1:0]           z_index_q, z_index_d;
  logic                       mode_err_q, mode_err_d;

  logic                       z_load, adv, z_fire;
  logic [DATA_W-1:0]          eps;
  logic signed [2*DATA_W-1:0] shifted;
  logic [DATA_W-1:0]          t_sat;
  logic [DATA_W:0]            sum;
  logic [DATA_W-1:0]          z_next;

  // Stage-2 arithmetic: floor-shift the product back to Q8.8, saturate, add mu, saturate again.
  always_comb begin
    eps     = det_en ? det_eps : {{(DATA_W-9){lfsr_q[8]}}, lfsr_q[8:0]};
    shifted = s1_prod_q >>> 8;
    if ((&shifted[2*DATA_W-1:DATA_W-1]) || !(|shifted[2*DATA_W-1:DATA_W-1])) begin
      t_sat = shifted[DATA_W-1:0];
    end else begin
      t_sat = shifted[2*DATA_W-1] ? SMIN : SMAX;
    end
    sum = {s1_mu_q[DATA_W-1], s1_mu_q} + {t_sat[DATA_W-1], t_sat};
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      z_next = sum[DATA_W] ? SMIN : SMAX;
    end else begin
      z_next = sum[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    mode_err_d = mode_err_q;
    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_mu_d    = s1_mu_q;
    s1_idx_d   = s1_idx_q;
    z_valid_d  = z_valid_q;
    z_data_d   = z_data_q;
    z_index_d  = z_index_q;
    mu_we      = 1'b0;
    in_ready   = 1'b0;
    frame_done = 1'b0;

    z_load = !z_valid_q || z_ready;
    adv    = !s1_valid_q || z_load;
    z_fire = z_valid_q && z_ready;

    if (z_load) begin
      z_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        z_data_d  = z_next;
        z_index_d = s1_idx_q;
      end
    end
    if (adv) begin
      s1_valid_d = 1'b0;
    end

    case (state_q)
      COLLECT_MU: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_mode) begin
            mode_err_d = 1'b1;
          end else begin
            mu_we = 1'b1;
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = COLLECT_SIG;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      COLLECT_SIG: begin
        in_ready = adv;
        if (in_valid && adv) begin
          if (!in_mode) begin
            mode_err_d = 1'b1;
          end else begin
            s1_valid_d = 1'b1;
            s1_prod_d  = $signed({{DATA_W{in_data[DATA_W-1]}}, in_data})
                       * $signed({{DATA_W{eps[DATA_W-1]}}, eps});
            s1_mu_d    = mu_buf_q[cnt_q];
            s1_idx_d   = cnt_q;
            lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
            if (cnt_q == LAST) begin
              state_d = DRAIN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (z_fire && z_index_q == LAST) begin
          frame_done = 1'b1;
          cnt_d      = '0;
          state_d    = COLLECT_MU;
        end
      end
      default: state_d = COLLECT_MU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q    <= COLLECT_MU;
      cnt_q      <= '0;
      mode_err_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_mu_q    <= '0;
      s1_idx_q   <= '0;
      z_valid_q  <= 1'b0;
      z_data_q   <= '0;
      z_index_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_err_q <= mode_err_d;
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_mu_q    <= s1_mu_d;
      s1_idx_q   <= s1_idx_d;
      z_valid_q  <= z_valid_d;
      z_data_q   <= z_data_d;
      z_index_q  <= z_index_d;
    end
  end

  // Soft clear keeps the noise sequence running so successive frames stay decorrelated.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (!clr) begin
      lfsr_q <= lfsr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mu_we) begin
      mu_buf_q[cnt_q] <= in_data;
    end
  end

  assign z_valid  = z_valid_q;
  assign z_data   = z_data_q;
  assign z_index  = z_index_q;
  assign mode_err = mode_err_q;

endmodule

// File: tb/tb_latent_sampler.sv
// tb/tb_latent_sampler.sv - self-checking bench for latent_sampler
// Table vectors, hand-written corner sequences and random frames against an integer reference model.
module tb_latent_sampler;

  localparam int          NL   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready, in_mode, det_en;
  logic        z_valid, frame_done, mode_err;
  logic        z_ready = 1'b1;
  logic [15:0] in_data, det_eps, z_data;
  logic [1:0]  z_index;

  always #5 clk = ~clk;

  latent_sampler #(.N_LATENT(NL), .IDX_W(2), .DATA_W(16), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .det_en(det_en), .det_eps(det_eps),
    .z_valid(z_valid), .z_ready(z_ready), .z_data(z_data), .z_index(z_index),
    .frame_done(frame_done), .mode_err(mode_err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rdy_mode = 0;
  int          sig_acc = 0;
  int          stray_fd = 0;
  logic [15:0] got_dat[$];
  int          got_idx[$];
  bit          got_fd[$];
  logic [15:0] model_lfsr;
  bit          model_err;
  logic [15:0] fmu[NL], fsig[NL], feps[NL], exp_z[NL];
  bit          fdet[NL];

  typedef struct {
    logic [15:0] mu;
    logic [15:0] sig;
    logic [15:0] eps;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[8];

  always begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       z_ready = 1'b1;
      1:       z_ready = 1'($urandom_range(0, 1));
      default: z_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && !clr) begin
      if (z_valid && z_ready) begin
        got_dat.push_back(z_data);
        got_idx.push_back(int'(z_index));
        got_fd.push_back(frame_done);
      end
      if (frame_done && !(z_valid && z_ready)) stray_fd++;
      if (in_valid && in_ready && in_mode) sig_acc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [15:0] ref_z(input logic [15:0] mu, input logic [15:0] sig,
                                       input logic [15:0] eps);
    int p, t, s;
    p = int'($signed(sig)) * int'($signed(eps));
    t = clamp16(p >>> 8);
    s = clamp16(int'($signed(mu)) + t);
    return 16'(s);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] lfsr_eps(input logic [15:0] v);
    int e;
    e = int'(v[8:0]);
    if (e > 255) e -= 512;
    return 16'(e);
  endfunction

  task automatic clear_got;
    got_dat.delete();
    got_idx.delete();
    got_fd.delete();
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_lfsr = SEED;
    model_err  = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input logic m, input logic de,
                           input logic [15:0] e);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_mode = m; det_en = de; det_eps = e;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready stuck at 0, want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input string tag);
    int c;
    c = 0;
    while (got_dat.size() < n && c < 400) begin
      @(posedge clk);
      c++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_count"}, got_dat.size(), n);
  endtask

  task automatic run_frame(input string tag, input bit inj);
    clear_got();
    for (int i = 0; i < NL; i++) begin
      if (inj && $urandom_range(0, 3) == 0) begin
        send_word(16'($urandom), 1'b1, 1'b0, 16'h0);
        model_err = 1'b1;
      end
      send_word(fmu[i], 1'b0, 1'b0, 16'h0);
    end
    for (int i = 0; i < NL; i++) begin
      if (inj && $urandom_range(0, 3) == 0) begin
        send_word(16'($urandom), 1'b0, 1'b0, 16'h0);
        model_err = 1'b1;
      end
      exp_z[i]   = ref_z(fmu[i], fsig[i], fdet[i] ? feps[i] : lfsr_eps(model_lfsr));
      model_lfsr = lfsr_next(model_lfsr);
      send_word(fsig[i], 1'b1, fdet[i], feps[i]);
    end
    wait_outputs(NL, tag);
    for (int i = 0; i < NL && i < got_dat.size(); i++) begin
      chk($sformatf("%s_idx[%0d]", tag, i), got_idx[i], i);
      chk($sformatf("%s_z[%0d]", tag, i), got_dat[i], exp_z[i]);
      chk($sformatf("%s_fd[%0d]", tag, i), got_fd[i], (i == NL - 1));
    end
    chk({tag, "_mode_err"}, mode_err, model_err);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
    det_en = 1'b0; det_eps = '0;
    tbl[0] = '{16'h0100, 16'h0200, 16'h0000, 16'h0100};
    tbl[1] = '{16'h0100, 16'h0200, 16'h0080, 16'h0200};
    tbl[2] = '{16'h0100, 16'h0200, 16'hFF80, 16'h0000};
    tbl[3] = '{16'h7000, 16'h7FFF, 16'h0100, 16'h7FFF};
    tbl[4] = '{16'h9000, 16'h7FFF, 16'hFF00, 16'h8000};
    tbl[5] = '{16'hFF00, 16'h0100, 16'h0180, 16'h0080};
    tbl[6] = '{16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF};
    tbl[7] = '{16'h0000, 16'h8000, 16'h8000, 16'h7FFF};

    do_reset();
    chk("rst_z_valid", z_valid, 0);
    chk("rst_z_data", z_data, 0);
    chk("rst_z_index", z_index, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_mode_err", mode_err, 0);
    chk("rst_in_ready", in_ready, 1);

    // Latency: each z appears two cycles after its sigma; frame_done with the last one.
    clear_got();
    for (int i = 0; i < NL; i++) send_word(16'h0100, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < NL; i++) begin
      model_lfsr = lfsr_next(model_lfsr);
      send_word(16'h0200, 1'b1, 1'b1, 16'h0000);
      chk($sformatf("lat_pre[%0d]", i), z_valid, 0);
      if (i == NL - 1) chk("drain_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk($sformatf("lat_valid[%0d]", i), z_valid, 1);
      chk($sformatf("lat_idx[%0d]", i), z_index, i);
      chk($sformatf("lat_z[%0d]", i), z_data, 16'h0100);
      chk($sformatf("lat_fd[%0d]", i), frame_done, (i == NL - 1));
      @(posedge clk); #1;
    end
    chk("post_frame_in_ready", in_ready, 1);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NL; i++) begin
        fmu[i] = tbl[k].mu; fsig[i] = tbl[k].sig; feps[i] = tbl[k].eps; fdet[i] = 1'b1;
      end
      run_frame($sformatf("tbl%0d", k), 1'b0);
      for (int i = 0; i < got_dat.size(); i++)
        chk($sformatf("tbl%0d_const[%0d]", k, i), got_dat[i], tbl[k].exp);
    end

    // LFSR noise from the reset seed.
    do_reset();
    for (int i = 0; i < NL; i++) begin
      fmu[i] = 16'h0000; fsig[i] = 16'h0100; fdet[i] = 1'b0; feps[i] = 16'h0;
    end
    run_frame("lfsr", 1'b0);
    if (got_dat.size() > 0) chk("lfsr_first", got_dat[0], 16'h00E1);

    // Backpressure: two sigmas in flight then in_ready drops; z holds stable.
    for (int i = 0; i < NL; i++) begin
      fmu[i] = 16'($urandom); fsig[i] = 16'($urandom_range(0, 16'h0800));
      fdet[i] = 1'($urandom_range(0, 1)); feps[i] = 16'($urandom);
    end
    clear_got();
    for (int i = 0; i < NL; i++) send_word(fmu[i], 1'b0, 1'b0, 16'h0);
    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < NL; i++) begin
      exp_z[i]   = ref_z(fmu[i], fsig[i], fdet[i] ? feps[i] : lfsr_eps(model_lfsr));
      model_lfsr = lfsr_next(model_lfsr);
    end
    sig_acc = 0;
    fork
      begin
        for (int i = 0; i < NL; i++) send_word(fsig[i], 1'b1, fdet[i], feps[i]);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_accepts", sig_acc, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold_valid", z_valid, 1);
        chk("bp_hold_idx", z_index, 0);
        chk("bp_hold_z", z_data, exp_z[0]);
        rdy_mode = 0;
      end
    join
    wait_outputs(NL, "bp");
    for (int i = 0; i < NL && i < got_dat.size(); i++) begin
      chk($sformatf("bp_idx[%0d]", i), got_idx[i], i);
      chk($sformatf("bp_z[%0d]", i), got_dat[i], exp_z[i]);
    end

    // Wrong mode during COLLECT_MU: flagged, counter untouched.
    send_word(16'h1234, 1'b1, 1'b0, 16'h0);
    model_err = 1'b1;
    chk("mode_err_set", mode_err, 1);
    for (int i = 0; i < NL; i++) begin
      fmu[i] = 16'((i + 1) * 256); fsig[i] = 16'h0100; fdet[i] = 1'b1; feps[i] = 16'h0100;
    end
    run_frame("after_err", 1'b0);

    // Soft clear mid COLLECT_SIG: in-flight z discarded, LFSR continues.
    for (int i = 0; i < NL; i++) send_word(16'($urandom), 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 2; i++) begin
      model_lfsr = lfsr_next(model_lfsr);
      send_word(16'h0100, 1'b1, 1'b0, 16'h0);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_err = 1'b0;
    chk("clr_z_valid", z_valid, 0);
    chk("clr_mode_err", mode_err, 0);
    chk("clr_in_ready", in_ready, 1);
    clear_got();
    repeat (5) @(posedge clk);
    #1;
    chk("clr_discard", got_dat.size(), 0);
    for (int i = 0; i < NL; i++) begin
      fmu[i] = 16'($urandom); fsig[i] = 16'($urandom); fdet[i] = 1'b0; feps[i] = 16'h0;
    end
    run_frame("clr_lfsr", 1'b0);

    rdy_mode = 1;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < NL; i++) begin
        fmu[i]  = 16'($urandom);
        fsig[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h0400));
        fdet[i] = 1'($urandom_range(0, 1));
        feps[i] = 16'($urandom);
      end
      run_frame($sformatf("rnd%0d", f), 1'b1);
    end
    rdy_mode = 0;
    chk("stray_frame_done", stray_fd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
